// File: rtl/verifier_chi_pkg.sv
// Shared types and modular-arithmetic helpers for the chi expansion block.
// Latency: n/a (package). Backpressure: n/a.
// Field width and modulus come from `F_NBITS / `F_Q; defaults below cover the 2^61-1 field.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

package verifier_chi_pkg;

    localparam int unsigned FW = `F_NBITS;
    localparam logic [FW-1:0] FQ = `F_Q;

    typedef logic [FW-1:0] fe_t;

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DRAIN} state_t;

    // Round counter must hold 0..n_bits-1 (one spare code keeps n_bits=1 legal).
    // The table index is simply n_bits wide.
    function automatic int rnd_w(input int n_bits);
        return $clog2(n_bits + 1);
    endfunction

    function automatic fe_t mod_add(input fe_t a, input fe_t b);
        logic [FW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, FQ}) s = s - {1'b0, FQ};
        return s[FW-1:0];
    endfunction

    // Borrow shows up in the extra top bit; adding q back lands in [0, q).
    function automatic fe_t mod_sub(input fe_t a, input fe_t b);
        logic [FW:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[FW]) d = d + {1'b0, FQ};
        return d[FW-1:0];
    endfunction

    function automatic fe_t mod_mul(input fe_t a, input fe_t b);
        return fe_t'(({{FW{1'b0}}, a} * {{FW{1'b0}}, b}) % {{FW{1'b0}}, FQ});
    endfunction

endpackage

// File: rtl/verifier_compute_chi_mulsub.sv
// Pipelined multiply-subtract: prod = a*b mod q, diff = a - prod mod q, tagged with idx.
// Latency: MUL_LAT cycles. Backpressure: none, accepts one op per cycle; flush_i kills in-flight ops.
// Ports: clk_i, rst_i, flush_i, valid_i/idx_i/a_i/b_i in; valid_o/idx_o/prod_o/diff_o out.
module verifier_compute_chi_mulsub
    import verifier_chi_pkg::*;
#(
    parameter int IDX_W   = 2,
    parameter int MUL_LAT = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [IDX_W-1:0] idx_i,
    input  fe_t              a_i,
    input  fe_t              b_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o,
    output fe_t              prod_o,
    output fe_t              diff_o
);

    fe_t prod_c;
    fe_t diff_c;

    assign prod_c = mod_mul(a_i, b_i);
    assign diff_c = mod_sub(a_i, prod_c);

    logic [MUL_LAT-1:0]            vld_q;
    logic [MUL_LAT-1:0][IDX_W-1:0] idx_q;
    fe_t  [MUL_LAT-1:0]            prod_q;
    fe_t  [MUL_LAT-1:0]            diff_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= valid_i;
            for (int k = 1; k < MUL_LAT; k++) vld_q[k] <= vld_q[k-1];
        end
    end

    // Payload needs no reset: it is only consumed under vld_q.
    always_ff @(posedge clk_i) begin
        idx_q[0]  <= idx_i;
        prod_q[0] <= prod_c;
        diff_q[0] <= diff_c;
        for (int k = 1; k < MUL_LAT; k++) begin
            idx_q[k]  <= idx_q[k-1];
            prod_q[k] <= prod_q[k-1];
            diff_q[k] <= diff_q[k-1];
        end
    end

    assign valid_o = vld_q[MUL_LAT-1];
    assign idx_o   = idx_q[MUL_LAT-1];
    assign prod_o  = prod_q[MUL_LAT-1];
    assign diff_o  = diff_q[MUL_LAT-1];

endmodule

// File: rtl/verifier_compute_chi_expand.sv
// Expands nCopyBits taus into the 2^nCopyBits chi weight table, in place, via one mul-sub unit.
// Latency: 1 + (nCopies-1) + nCopyBits*MUL_LAT cycles from accepted en to ready_o. Backpressure: en ignored while busy.
// Ports: clk_i, rst_i, en_i, restart_i, tau_i in; out_vals_o, ready_o, ready_pulse_o (+ sum_ok_o with VERIFIER_COMPUTE_CHI_SUMCHECK_EN).
module verifier_compute_chi_expand
    import verifier_chi_pkg::*;
#(
    parameter  int nCopyBits = 2,
    parameter  int MUL_LAT   = 2,
    localparam int nCopies   = 1 << nCopyBits
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      restart_i,
    input  fe_t  [nCopyBits-1:0]      tau_i,
    output fe_t  [nCopies-1:0]        out_vals_o,
    output logic                      ready_o,
    output logic                      ready_pulse_o
`ifdef VERIFIER_COMPUTE_CHI_SUMCHECK_EN
    ,
    output logic                      sum_ok_o
`endif
);

    generate
        if (nCopyBits < 1) begin : g_bad_copy_bits
            $error("nCopyBits must be at least 1");
        end
        if (MUL_LAT < 1) begin : g_bad_mul_lat
            $error("MUL_LAT must be at least 1");
        end
    endgenerate

    localparam int RW = rnd_w(nCopyBits);
    localparam int DW = $clog2(MUL_LAT + 1);
    localparam logic [RW-1:0] LAST_RND = RW'(nCopyBits - 1);

    state_t                 state_q;
    logic [RW-1:0]          rnd_q;
    logic [nCopyBits-1:0]   cnt_q;      // issue index, counts down
    logic [DW-1:0]          dcnt_q;     // drain cycles remaining
    fe_t  [nCopyBits-1:0]   tau_q;
    fe_t  [nCopies-1:0]     tab_q;
    logic                   ready_q;
    logic                   pulse_q;

    // Round r consumes the taus from the top: tau[nCopyBits-1-r].
    logic [RW-1:0] bsel;
    fe_t           iss_b;
    always_comb begin
        bsel  = LAST_RND - rnd_q;
        iss_b = '0;
        for (int j = 0; j < nCopyBits; j++) begin
            if (RW'(j) == bsel) iss_b = tau_q[j];
        end
    end

    logic                 ret_vld;
    logic [nCopyBits-1:0] ret_idx;
    fe_t                  ret_prod;
    fe_t                  ret_diff;

    verifier_compute_chi_mulsub #(
        .IDX_W   (nCopyBits),
        .MUL_LAT (MUL_LAT)
    ) u_mulsub (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (restart_i),
        .valid_i (state_q == ISSUE),
        .idx_i   (cnt_q),
        .a_i     (tab_q[cnt_q]),
        .b_i     (iss_b),
        .valid_o (ret_vld),
        .idx_o   (ret_idx),
        .prod_o  (ret_prod),
        .diff_o  (ret_diff)
    );

    logic [nCopyBits-1:0] wr_odd;
    logic [nCopyBits-1:0] wr_even;
    logic [nCopyBits-1:0] cnt_top_d;

    assign wr_odd    = nCopyBits'({ret_idx, 1'b1});
    assign wr_even   = nCopyBits'({ret_idx, 1'b0});
    assign cnt_top_d = nCopyBits'((2 << rnd_q) - 1);   // 2^(r+1)-1 for the next round

`ifdef VERIFIER_COMPUTE_CHI_SUMCHECK_EN
    // prod + diff of a retire equals its a; final-round entries sum to 1 when the table is sound.
    fe_t  acc_q;
    fe_t  acc_d;
    logic sum_ok_q;
    always_comb begin
        acc_d = acc_q;
        if (ret_vld && rnd_q == LAST_RND) acc_d = mod_add(acc_q, mod_add(ret_prod, ret_diff));
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            tau_q   <= '0;
            tab_q   <= '0;
            ready_q <= 1'b1;
            pulse_q <= 1'b0;
`ifdef VERIFIER_COMPUTE_CHI_SUMCHECK_EN
            acc_q    <= '0;
            sum_ok_q <= 1'b0;
`endif
        end else if (restart_i) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            pulse_q <= 1'b0;
`ifdef VERIFIER_COMPUTE_CHI_SUMCHECK_EN
            sum_ok_q <= 1'b0;
`endif
        end else begin
            pulse_q <= 1'b0;
            if (ret_vld) begin
                tab_q[wr_odd]  <= ret_prod;
                tab_q[wr_even] <= ret_diff;
            end
`ifdef VERIFIER_COMPUTE_CHI_SUMCHECK_EN
            acc_q <= acc_d;
`endif
            case (state_q)
                IDLE: begin
                    if (en_i) begin
                        tau_q   <= tau_i;
                        ready_q <= 1'b0;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    tab_q[0] <= fe_t'(1);
                    rnd_q    <= '0;
                    cnt_q    <= '0;
                    state_q  <= ISSUE;
`ifdef VERIFIER_COMPUTE_CHI_SUMCHECK_EN
                    acc_q    <= '0;
                    sum_ok_q <= 1'b0;
`endif
                end
                ISSUE: begin
                    if (cnt_q == '0) begin
                        dcnt_q  <= DW'(MUL_LAT - 1);
                        state_q <= DRAIN;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DRAIN: begin
                    if (dcnt_q != '0) begin
                        dcnt_q <= dcnt_q - 1'b1;
                    end else if (rnd_q == LAST_RND) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        pulse_q <= 1'b1;
`ifdef VERIFIER_COMPUTE_CHI_SUMCHECK_EN
                        sum_ok_q <= (acc_d == fe_t'(1));
`endif
                    end else begin
                        rnd_q   <= rnd_q + 1'b1;
                        cnt_q   <= cnt_top_d;
                        state_q <= ISSUE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_vals_o    = tab_q;
    assign ready_o       = ready_q;
    assign ready_pulse_o = pulse_q;
`ifdef VERIFIER_COMPUTE_CHI_SUMCHECK_EN
    assign sum_ok_o      = sum_ok_q;
`endif

endmodule
